// File: rtl/axis_apb_pkg.sv
// Shared definitions for the counting-pattern stream sink and its APB block:
// register map, receive FSM encoding, STATUS/CONTROL bit positions.
package axis_apb_pkg;

  // APB register map (byte addresses), shared with the stream generator
  localparam logic [7:0] APB_ADDR_CONTROL      = 8'h00;
  localparam logic [7:0] APB_ADDR_STATUS       = 8'h04;
  localparam logic [7:0] APB_ADDR_PKT_COUNT    = 8'h08;
  localparam logic [7:0] APB_ADDR_ERR_COUNT    = 8'h0C;
  localparam logic [7:0] APB_ADDR_EXPECT_BYTES = 8'h10;
  localparam logic [7:0] APB_ADDR_LAST_BEATS   = 8'h14;
  localparam logic [7:0] APB_ADDR_LAST_ID      = 8'h18;

  // Receive FSM encoding
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_WAIT = 2'd1,
    RX_RECV = 2'd2
  } rx_state_t;

  // STATUS bit positions
  localparam int STAT_IN_PACKET = 0;
  localparam int STAT_DATA_ERR  = 1;
  localparam int STAT_LEN_ERR   = 2;
  localparam int STAT_DONE      = 3;

  // CONTROL bit positions
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_CLEAR    = 1;
  localparam int CTRL_STALL_EN = 2;
  localparam int CTRL_IRQ_EN   = 3;

endpackage

// File: rtl/axi_stream_sink_apb_if.sv
// Bundle of the AXI4-Stream sink signals and the APB slave signals.
// Handshake rules: a stream beat transfers on a rising PCLK edge where
// TVALID and TREADY are both 1; the source holds TDATA/TLAST/TID/TDEST
// stable while TVALID=1 and TREADY=0. An APB access is a setup cycle
// (PSEL=1, PENABLE=0) followed by an access cycle (PSEL=1, PENABLE=1);
// PREADY is always 1, so every access completes in the access cycle.
interface axi_stream_sink_apb_if #(
  parameter int STREAM_DATA_WIDTH = 32,
  parameter int STREAM_ID_WIDTH   = 2,
  parameter int C_APB_DATA_WIDTH  = 32,
  parameter int C_APB_ADDR_WIDTH  = 5
);
  logic [STREAM_DATA_WIDTH-1:0] TDATA;
  logic                         TLAST;
  logic [STREAM_ID_WIDTH-1:0]   TID;
  logic [1:0]                   TDEST;
  logic                         TVALID;
  logic                         TREADY;
  logic                         PSEL;
  logic                         PENABLE;
  logic                         PWRITE;
  logic [C_APB_ADDR_WIDTH-1:0]  PADDR;
  logic [C_APB_DATA_WIDTH-1:0]  PWDATA;
  logic [C_APB_DATA_WIDTH-1:0]  PRDATA;
  logic                         PREADY;
  logic                         PSLVERR;

  modport master (
    output TDATA, TLAST, TID, TDEST, TVALID,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  TREADY, PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  TDATA, TLAST, TID, TDEST, TVALID,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output TREADY, PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/axis_sink_apb_regs.sv
// APB register block of the stream sink: address decode, CONTROL and
// EXPECT_BYTES registers, sticky STATUS bits with write-1-to-clear, and
// the combinational read mux.
module axis_sink_apb_regs
  import axis_apb_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int BYTES = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  input  logic          in_packet,
  input  logic          set_data_err,
  input  logic          set_len_err,
  input  logic          set_done,
  input  logic [31:0]   pkt_count,
  input  logic [31:0]   err_count,
  input  logic [31:0]   last_beats,
  input  logic [31:0]   last_id,
  output logic [DW-1:0] prdata,
  output logic          enable,
  output logic          stall_en,
  output logic          clear,
  output logic [23:0]   expect_beats,
  output logic          irq
);

  logic          enable_q;
  logic          stall_en_q;
  logic          irq_en_q;
  logic [DW-1:0] expect_q;
  logic          data_err_q;
  logic          len_err_q;
  logic          done_q;

  logic wr;
  logic wr_ctrl;
  logic wr_stat;
  logic wr_expect;

  assign wr        = psel & penable & pwrite;
  assign wr_ctrl   = wr && (paddr == AW'(APB_ADDR_CONTROL));
  assign wr_stat   = wr && (paddr == AW'(APB_ADDR_STATUS));
  assign wr_expect = wr && (paddr == AW'(APB_ADDR_EXPECT_BYTES));

  // clear acts in the same cycle as the CONTROL write and is never stored
  assign clear        = wr_ctrl & pwdata[CTRL_CLEAR];
  assign enable       = enable_q;
  assign stall_en     = stall_en_q;
  assign irq          = done_q & irq_en_q;
  assign expect_beats = expect_q[23:0] / 24'(BYTES);

  // Control registers and sticky status: clear beats everything, a set beats W1C
  always_ff @(posedge clk) begin
    if (!resetn) begin
      enable_q   <= 1'b0;
      stall_en_q <= 1'b0;
      irq_en_q   <= 1'b0;
      expect_q   <= '0;
      data_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable_q   <= pwdata[CTRL_ENABLE];
        stall_en_q <= pwdata[CTRL_STALL_EN];
        irq_en_q   <= pwdata[CTRL_IRQ_EN];
      end
      if (wr_expect) begin
        expect_q <= pwdata;
      end
      if (clear) begin
        data_err_q <= 1'b0;
        len_err_q  <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        data_err_q <= set_data_err | (data_err_q & ~(wr_stat & pwdata[STAT_DATA_ERR]));
        len_err_q  <= set_len_err  | (len_err_q  & ~(wr_stat & pwdata[STAT_LEN_ERR]));
        done_q     <= set_done     | (done_q     & ~(wr_stat & pwdata[STAT_DONE]));
      end
    end
  end

  // Read mux, decoded from PADDR alone; unmapped addresses read 0
  always_comb begin
    prdata = '0;
    case (paddr)
      AW'(APB_ADDR_CONTROL):      prdata = DW'({irq_en_q, stall_en_q, 1'b0, enable_q});
      AW'(APB_ADDR_STATUS):       prdata = DW'({done_q, len_err_q, data_err_q, in_packet});
      AW'(APB_ADDR_PKT_COUNT):    prdata = DW'(pkt_count);
      AW'(APB_ADDR_ERR_COUNT):    prdata = DW'(err_count);
      AW'(APB_ADDR_EXPECT_BYTES): prdata = expect_q;
      AW'(APB_ADDR_LAST_BEATS):   prdata = DW'(last_beats);
      AW'(APB_ADDR_LAST_ID):      prdata = DW'(last_id);
      default:                    prdata = '0;
    endcase
  end

endmodule

// File: rtl/axi_stream_sink_apb.sv
// AXI4-Stream sink that checks an incrementing data pattern (restarting at
// 0 each packet) and the packet length, counting good and bad packets.
// Control/status through the APB register block.
module axi_stream_sink_apb
  import axis_apb_pkg::*;
#(
  parameter int STREAM_DATA_WIDTH = 32,
  parameter int STREAM_ID_WIDTH   = 2,
  parameter int C_APB_DATA_WIDTH  = 32,
  parameter int C_APB_ADDR_WIDTH  = 5
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  axi_stream_sink_apb_if.slave bus,
  output logic                 IRQ,
  output logic [1:0]           dbg_state
);

  localparam int STREAM_DATA_BYTES = STREAM_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = RX_IDLE;
  localparam logic [1:0] ST_WAIT = RX_WAIT;
  localparam logic [1:0] ST_RECV = RX_RECV;

  logic [1:0]                   state_q;
  logic                         tready_q;
  logic                         stall_tgl_q;
  logic [STREAM_DATA_WIDTH-1:0] exp_data_q;
  logic [23:0]                  beat_cnt_q;
  logic                         pkt_bad_q;
  logic [31:0]                  pkt_count_q;
  logic [31:0]                  err_count_q;
  logic [31:0]                  last_beats_q;
  logic [31:0]                  last_id_q;

  logic        enable;
  logic        stall_en;
  logic        clear;
  logic [23:0] expect_beats;
  logic        accept;
  logic        complete;
  logic        data_mis;
  logic        len_mis;
  logic        pkt_bad;
  logic [31:0] beats_total;
  logic [31:0] id_word;

  assign bus.TREADY  = tready_q;
  assign bus.PREADY  = 1'b1;
  assign bus.PSLVERR = 1'b0;
  assign dbg_state   = state_q;

  // A beat only counts while enabled and out of IDLE; a beat that slips in
  // during the cycle enable drops belongs to the discarded partial packet.
  assign accept      = bus.TVALID & tready_q & enable & (state_q != ST_IDLE);
  assign complete    = accept & bus.TLAST;
  assign data_mis    = (bus.TDATA != exp_data_q);
  assign beats_total = {8'd0, beat_cnt_q} + 32'd1;
  assign len_mis     = (beats_total != {8'd0, expect_beats});
  assign pkt_bad     = pkt_bad_q | data_mis | len_mis;

  // LAST_ID layout: TDEST in [1:0], TID from bit 8 upward
  always_comb begin
    id_word = '0;
    id_word[1:0] = bus.TDEST;
    id_word[8 +: STREAM_ID_WIDTH] = bus.TID;
  end

  // Ready generation: optional 50% duty stall via a free-running toggle
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      stall_tgl_q <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      stall_tgl_q <= enable ? ~stall_tgl_q : 1'b0;
      tready_q    <= enable & (stall_en ? ~stall_tgl_q : 1'b1);
    end
  end

  // Receive FSM with pattern and length tracking for the current packet
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      exp_data_q <= '0;
      beat_cnt_q <= '0;
      pkt_bad_q  <= 1'b0;
    end else if (!enable) begin
      state_q    <= ST_IDLE;
      exp_data_q <= '0;
      beat_cnt_q <= '0;
      pkt_bad_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_WAIT;
        ST_WAIT, ST_RECV: begin
          if (accept) begin
            if (bus.TLAST) begin
              state_q    <= ST_WAIT;
              exp_data_q <= '0;
              beat_cnt_q <= '0;
              pkt_bad_q  <= 1'b0;
            end else begin
              state_q    <= ST_RECV;
              exp_data_q <= exp_data_q + 1'b1;
              beat_cnt_q <= (beat_cnt_q == 24'hFF_FFFF) ? beat_cnt_q : beat_cnt_q + 24'd1;
              pkt_bad_q  <= pkt_bad_q | data_mis;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Packet counters and last-packet info; clear wins over a completion
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pkt_count_q  <= '0;
      err_count_q  <= '0;
      last_beats_q <= '0;
      last_id_q    <= '0;
    end else if (clear) begin
      pkt_count_q  <= '0;
      err_count_q  <= '0;
      last_beats_q <= '0;
      last_id_q    <= '0;
    end else if (complete) begin
      if (pkt_bad) err_count_q <= err_count_q + 32'd1;
      else         pkt_count_q <= pkt_count_q + 32'd1;
      last_beats_q <= beats_total;
      last_id_q    <= id_word;
    end
  end

  axis_sink_apb_regs #(
    .AW    (C_APB_ADDR_WIDTH),
    .DW    (C_APB_DATA_WIDTH),
    .BYTES (STREAM_DATA_BYTES)
  ) u_regs (
    .clk          (PCLK),
    .resetn       (PRESETn),
    .psel         (bus.PSEL),
    .penable      (bus.PENABLE),
    .pwrite       (bus.PWRITE),
    .paddr        (bus.PADDR),
    .pwdata       (bus.PWDATA),
    .in_packet    (state_q == ST_RECV),
    .set_data_err (accept & data_mis),
    .set_len_err  (complete & len_mis),
    .set_done     (complete),
    .pkt_count    (pkt_count_q),
    .err_count    (err_count_q),
    .last_beats   (last_beats_q),
    .last_id      (last_id_q),
    .prdata       (bus.PRDATA),
    .enable       (enable),
    .stall_en     (stall_en),
    .clear        (clear),
    .expect_beats (expect_beats),
    .irq          (IRQ)
  );

endmodule

// File: tb/tb_axi_stream_sink_apb.sv
// Directed bench for axi_stream_sink_apb: APB register programming, packet
// pattern/length checks, stall duty, disable mid-packet, clear/completion
// collision and reset mid-packet.
module tb_axi_stream_sink_apb;

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_STAT   = 5'h04;
  localparam logic [4:0] A_PKT    = 5'h08;
  localparam logic [4:0] A_ERR    = 5'h0C;
  localparam logic [4:0] A_EXPECT = 5'h10;
  localparam logic [4:0] A_LBEATS = 5'h14;
  localparam logic [4:0] A_LID    = 5'h18;

  logic       pclk;
  logic       presetn;
  logic       irq;
  logic [1:0] dbg_state;

  int tests;
  int fails;
  int fire_cnt;

  axi_stream_sink_apb_if bus ();

  axi_stream_sink_apb dut (
    .PCLK      (pclk),
    .PRESETn   (presetn),
    .bus       (bus.slave),
    .IRQ       (irq),
    .dbg_state (dbg_state)
  );

  // clock and watchdog
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // beat monitor
  always @(posedge pclk) begin
    if (bus.TVALID && bus.TREADY) fire_cnt <= fire_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] data);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = addr; bus.PWDATA = data; bus.PENABLE = 1'b0;
    tick();
    bus.PENABLE = 1'b1;
    tick();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] addr, output logic [31:0] data);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = addr; bus.PENABLE = 1'b0;
    tick();
    bus.PENABLE = 1'b1;
    data = bus.PRDATA;
    tick();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    chk(tag, d, exp);
  endtask

  // Sends beats 0..n_send-1 of an n-beat packet; beat bad_idx carries bad_val.
  task automatic send_pkt(input int n, input int n_send, input int bad_idx,
                          input logic [31:0] bad_val, output int cyc);
    logic rdy;
    logic ok;
    ok  = 1'b1;
    cyc = 0;
    for (int i = 0; i < n_send; i++) begin
      bus.TVALID = 1'b1;
      bus.TDATA  = (i == bad_idx) ? bad_val : 32'(i);
      bus.TLAST  = (i == n - 1);
      rdy = 1'b0;
      while (!rdy && ok) begin
        rdy = bus.TREADY;
        tick();
        cyc++;
        if (cyc > 200) ok = 1'b0;
      end
      if (!ok) break;
    end
    bus.TVALID = 1'b0;
    bus.TLAST  = 1'b0;
    chk("send_no_timeout", {31'd0, ok}, 32'd1);
  endtask

  int          cyc;
  int          fires0;

  initial begin
    tests = 0; fails = 0; fire_cnt = 0;
    presetn = 1'b0;
    bus.TDATA = '0; bus.TLAST = 1'b0; bus.TID = 2'd2; bus.TDEST = 2'd1; bus.TVALID = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    repeat (3) tick();

    // reset state
    chk("rst_tready", {31'd0, bus.TREADY}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    presetn = 1'b1;
    tick();
    chk("pready", {31'd0, bus.PREADY}, 32'd1);
    chk("pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_status", A_STAT, 32'h0);
    rd_chk("rst_pkt", A_PKT, 32'h0);
    rd_chk("rst_unmapped", 5'h1C, 32'h0);

    // clean 4-beat packet
    apb_write(A_EXPECT, 32'd16);
    apb_write(A_CTRL, 32'h1);
    rd_chk("expect_rb", A_EXPECT, 32'd16);
    rd_chk("ctrl_rb", A_CTRL, 32'h1);
    send_pkt(4, 4, -1, 32'h0, cyc);
    rd_chk("t1_pkt", A_PKT, 32'd1);
    rd_chk("t1_err", A_ERR, 32'd0);
    rd_chk("t1_lbeats", A_LBEATS, 32'd4);
    rd_chk("t1_status", A_STAT, 32'h8);
    rd_chk("t1_lid", A_LID, 32'h201);
    chk("t1_irq_masked", {31'd0, irq}, 32'd0);
    apb_write(A_STAT, 32'h8);
    rd_chk("t1_w1c_done", A_STAT, 32'h0);

    // data error, then clean packet restarts pattern at 0
    apb_write(A_CTRL, 32'h3);
    rd_chk("clear_pkt", A_PKT, 32'd0);
    send_pkt(4, 4, 2, 32'h7, cyc);
    rd_chk("t2_err", A_ERR, 32'd1);
    rd_chk("t2_pkt", A_PKT, 32'd0);
    rd_chk("t2_status", A_STAT, 32'hA);
    send_pkt(4, 4, -1, 32'h0, cyc);
    rd_chk("t2_restart_pkt", A_PKT, 32'd1);
    rd_chk("t2_restart_err", A_ERR, 32'd1);

    // short packet length error, then 1-beat good packet
    apb_write(A_CTRL, 32'h3);
    apb_write(A_EXPECT, 32'd16);
    send_pkt(3, 3, -1, 32'h0, cyc);
    rd_chk("t3_status", A_STAT, 32'hC);
    rd_chk("t3_err", A_ERR, 32'd1);
    rd_chk("t3_lbeats", A_LBEATS, 32'd3);
    apb_write(A_EXPECT, 32'd4);
    send_pkt(1, 1, -1, 32'h0, cyc);
    rd_chk("t3_pkt1", A_PKT, 32'd1);
    rd_chk("t3_lbeats1", A_LBEATS, 32'd1);

    // irq level and W1C
    apb_write(A_CTRL, 32'h9);
    chk("t4_irq_on", {31'd0, irq}, 32'd1);
    apb_write(A_STAT, 32'hE);
    chk("t4_irq_off", {31'd0, irq}, 32'd0);
    rd_chk("t4_status", A_STAT, 32'h0);

    // zero-length expectation: every packet is a length error
    apb_write(A_CTRL, 32'h3);
    apb_write(A_EXPECT, 32'd2);
    send_pkt(1, 1, -1, 32'h0, cyc);
    rd_chk("t4z_err", A_ERR, 32'd1);
    rd_chk("t4z_status", A_STAT, 32'hC);

    // stall: 50% ready, 8 beats
    apb_write(A_CTRL, 32'h7);
    apb_write(A_EXPECT, 32'd32);
    fires0 = fire_cnt;
    send_pkt(8, 8, -1, 32'h0, cyc);
    chk("t5_fires", 32'(fire_cnt - fires0), 32'd8);
    chk("t5_duty", {31'd0, (cyc >= 15 && cyc <= 16)}, 32'd1);
    rd_chk("t5_pkt", A_PKT, 32'd1);
    rd_chk("t5_err", A_ERR, 32'd0);
    rd_chk("t5_status", A_STAT, 32'h8);

    // disable mid-packet
    apb_write(A_CTRL, 32'h3);
    apb_write(A_EXPECT, 32'd16);
    send_pkt(4, 2, -1, 32'h0, cyc);
    rd_chk("t6_in_packet", A_STAT, 32'h1);
    apb_write(A_CTRL, 32'h0);
    tick();
    chk("t6_tready_off", {31'd0, bus.TREADY}, 32'd0);
    chk("t6_state_idle", {30'd0, dbg_state}, 32'd0);
    rd_chk("t6_pkt", A_PKT, 32'd0);
    rd_chk("t6_err", A_ERR, 32'd0);
    rd_chk("t6_status", A_STAT, 32'h0);
    apb_write(A_CTRL, 32'h1);
    send_pkt(4, 4, -1, 32'h0, cyc);
    rd_chk("t6_reenable_pkt", A_PKT, 32'd1);
    rd_chk("t6_reenable_err", A_ERR, 32'd0);

    // clear in the same cycle as a TLAST fire
    apb_write(A_EXPECT, 32'd4);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = A_CTRL; bus.PWDATA = 32'h3; bus.PENABLE = 1'b0;
    tick();
    bus.PENABLE = 1'b1;
    bus.TVALID = 1'b1; bus.TDATA = 32'h0; bus.TLAST = 1'b1;
    chk("t7_tready", {31'd0, bus.TREADY}, 32'd1);
    tick();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.TVALID = 1'b0; bus.TLAST = 1'b0;
    rd_chk("t7_pkt", A_PKT, 32'd0);
    rd_chk("t7_err", A_ERR, 32'd0);
    rd_chk("t7_lbeats", A_LBEATS, 32'd0);
    rd_chk("t7_status", A_STAT, 32'h0);

    // reset mid-packet
    apb_write(A_CTRL, 32'h9);
    send_pkt(1, 1, -1, 32'h0, cyc);
    chk("t8_irq_pre", {31'd0, irq}, 32'd1);
    send_pkt(4, 2, -1, 32'h0, cyc);
    presetn = 1'b0;
    tick();
    chk("t8_tready", {31'd0, bus.TREADY}, 32'd0);
    chk("t8_irq", {31'd0, irq}, 32'd0);
    chk("t8_state", {30'd0, dbg_state}, 32'd0);
    presetn = 1'b1;
    rd_chk("t8_ctrl", A_CTRL, 32'h0);
    rd_chk("t8_pkt", A_PKT, 32'd0);
    rd_chk("t8_expect", A_EXPECT, 32'd0);
    rd_chk("t8_lid", A_LID, 32'd0);
    rd_chk("t8_status", A_STAT, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
